elevator_car_ctrl: RTL and testbench

ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

---
 rtl/elevator_car_ctrl_if.sv | 8 +
 rtl/elevator_car_ctrl.sv | 103 ++++++++++
 tb/tb_elevator_car_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/elevator_car_ctrl_if.sv
// elevator_car_ctrl_if: floor-request valid/ready handshake between a request source and the car controller
interface elevator_car_ctrl_if #(parameter int WIDTH = 4);
    logic             req_valid;
    logic [WIDTH-1:0] req_floor;
    logic             req_ready;
    modport master(output req_valid, req_floor, input req_ready);
    modport slave(input req_valid, req_floor, output req_ready);
endinterface

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: single-car controller; accepts one floor request in IDLE, travels floor by floor, dwells with doors open
module elevator_car_ctrl #(
    parameter int WIDTH        = 4,
    parameter int TOP_FLOOR    = 9,
    parameter int TRAVEL_TICKS = 4,
    parameter int DWELL_TICKS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    elevator_car_ctrl_if.slave   req,
    output logic [WIDTH-1:0]     floor,
    output logic                 moving,
    output logic                 dir_up,
    output logic                 door_open,
    output logic                 arrived,
    output logic                 err_range
);
    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DWELL_TICKS + 1);

    typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] target, target_n, floor_n;
    logic [TW-1:0]    tick, tick_n;
    logic [DW-1:0]    dwell, dwell_n;
    logic             dir_n, arr_n, err_n, accept;

    assign req.req_ready = (state == IDLE);
    assign moving        = (state == MOVE);
    assign door_open     = (state == DWELL);
    assign accept        = req.req_valid & req.req_ready;

    always_comb begin
        state_n  = state;
        target_n = target;
        floor_n  = floor;
        tick_n   = tick;
        dwell_n  = dwell;
        dir_n    = dir_up;
        arr_n    = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (req.req_floor > WIDTH'(TOP_FLOOR)) begin
                    err_n = 1'b1;
                end else if (req.req_floor == floor) begin
                    state_n = DWELL;
                    dwell_n = '0;
                    arr_n   = 1'b1;
                end else begin
                    target_n = req.req_floor;
                    dir_n    = req.req_floor > floor;
                    tick_n   = '0;
                    state_n  = MOVE;
                end
            end
            MOVE: if (enable) begin
                if (tick == TW'(TRAVEL_TICKS - 1)) begin
                    tick_n = '0;
                    // step is clamped so a corrupted target can never push the car off the shaft
                    floor_n = dir_up ? ((floor < WIDTH'(TOP_FLOOR)) ? floor + WIDTH'(1) : floor)
                                     : ((floor != '0) ? floor - WIDTH'(1) : floor);
                    if (floor_n == target) begin
                        state_n = DWELL;
                        dwell_n = '0;
                        arr_n   = 1'b1;
                    end
                end else begin
                    tick_n = tick + TW'(1);
                end
            end
            DWELL: begin
                state_n = (dwell == DW'(DWELL_TICKS - 1)) ? IDLE : DWELL;
                dwell_n = (dwell == DW'(DWELL_TICKS - 1)) ? '0 : dwell + DW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            floor     <= '0;
            tick      <= '0;
            dwell     <= '0;
            dir_up    <= 1'b1;
            arrived   <= 1'b0;
            err_range <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            floor     <= floor_n;
            tick      <= tick_n;
            dwell     <= dwell_n;
            dir_up    <= dir_n;
            arrived   <= arr_n;
            err_range <= err_n;
        end
    end
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed scenarios plus random traffic, checked each cycle against a countdown-based car model
module tb_elevator_car_ctrl;
    localparam int TOP = 9;
    localparam int TT  = 4;
    localparam int DT  = 3;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DWELL = 2;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [3:0] floor;
    logic       moving, dir_up, door_open, arrived, err_range;
    int         vectors = 0, miscompares = 0;
    int         m_mode, m_floor, m_target, m_left, m_dwell;
    bit         m_dir, m_arr, m_err;
    int         cnt;

    elevator_car_ctrl_if #(.WIDTH(4)) rif();

    elevator_car_ctrl #(.WIDTH(4), .TOP_FLOOR(TOP), .TRAVEL_TICKS(TT), .DWELL_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(rif),
        .floor(floor), .moving(moving), .dir_up(dir_up), .door_open(door_open),
        .arrived(arrived), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE; m_floor = 0; m_target = 0; m_left = 0; m_dwell = 0;
        m_dir = 1'b1; m_arr = 1'b0; m_err = 1'b0;
    endtask

    // left/dwell count down the enabled edges still owed, independent of how the DUT counts
    task automatic model_update();
        int rf;
        if (reset) begin model_reset(); return; end
        rf = int'(rif.req_floor);
        m_arr = 1'b0; m_err = 1'b0;
        if (m_mode == M_IDLE) begin
            if (rif.req_valid) begin
                if (rf > TOP) m_err = 1'b1;
                else if (rf == m_floor) begin m_mode = M_DWELL; m_dwell = DT; m_arr = 1'b1; end
                else begin m_target = rf; m_dir = rf > m_floor; m_left = TT; m_mode = M_MOVE; end
            end
        end else if (m_mode == M_MOVE) begin
            if (enable) begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_dir ? 1 : -1;
                    m_left = TT;
                    if (m_floor == m_target) begin m_mode = M_DWELL; m_dwell = DT; m_arr = 1'b1; end
                end
            end
        end else begin
            m_dwell--;
            if (m_dwell == 0) m_mode = M_IDLE;
        end
    endtask

    task automatic compare_all();
        logic [9:0] act, exp;
        act = {floor, moving, dir_up, door_open, arrived, err_range, rif.req_ready};
        exp = {4'(m_floor), m_mode == M_MOVE, m_dir, m_mode == M_DWELL, m_arr, m_err, m_mode == M_IDLE};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle t=%0t {floor,moving,dir_up,door_open,arrived,err_range,req_ready} got %h_%b expected %h_%b",
                     $time, act[9:6], act[5:0], exp[9:6], exp[5:0]);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] f, input logic e);
        rif.req_valid = v; rif.req_floor = f; enable = e;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; rif.req_valid = 1'b0; rif.req_floor = '0;
        model_reset();
        @(negedge clk);
        lit("reset floor", int'(floor), 0);
        lit("reset dir_up", int'(dir_up), 1);
        lit("reset req_ready", int'(rif.req_ready), 1);
        lit("reset moving", int'(moving), 0);
        step(1'b1, 4'd3, 1'b1);
        lit("reset ignores req", int'(moving), 0);
        reset = 1'b0;

        step(1'b1, 4'd3, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 4'd0, 1'b1);
            if (i == 4)  lit("up floor1 at +4", int'(floor), 1);
            if (i == 8)  lit("up floor2 at +8", int'(floor), 2);
            if (i == 12) begin
                lit("up floor3 at +12", int'(floor), 3);
                lit("up arrived at +12", int'(arrived), 1);
                lit("up door at +12", int'(door_open), 1);
            end
            if (i == 14) lit("dwell busy at +14", int'(rif.req_ready), 0);
            if (i == 15) lit("ready at +15", int'(rif.req_ready), 1);
        end

        step(1'b1, 4'd1, 1'b1);
        lit("down dir_up", int'(dir_up), 0);
        cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 4'd0, 1'b1);
            cnt += int'(arrived);
            if (i == 4) lit("down floor2 at +4", int'(floor), 2);
            if (i == 8) lit("down floor1 at +8", int'(floor), 1);
        end
        lit("down arrived pulses", cnt, 1);

        reset = 1'b1; step(1'b0, 4'd0, 1'b1); reset = 1'b0;
        step(1'b1, 4'd12, 1'b1);
        lit("range err pulse", int'(err_range), 1);
        lit("range floor", int'(floor), 0);
        lit("range ready", int'(rif.req_ready), 1);
        step(1'b0, 4'd0, 1'b1);
        lit("range err one cycle", int'(err_range), 0);
        step(1'b1, 4'd0, 1'b1);
        lit("same floor arrived", int'(arrived), 1);
        cnt = int'(door_open);
        for (int i = 0; i < 4; i++) begin step(1'b0, 4'd0, 1'b1); cnt += int'(door_open); end
        lit("same floor door cycles", cnt, 3);

        step(1'b1, 4'd2, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        for (int i = 3; i <= 7; i++) step(1'b0, 4'd0, 1'b0);
        lit("enable low holds floor", int'(floor), 0);
        for (int i = 8; i <= 13; i++) begin
            step(1'b0, 4'd0, 1'b1);
            if (i == 9)  lit("stall floor1 at +9", int'(floor), 1);
            if (i == 13) lit("stall floor2 at +13", int'(floor), 2);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1);

        step(1'b1, 4'd5, 1'b1);
        cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step(i == 2, 4'd1, 1'b1);
            cnt += int'(arrived);
        end
        lit("ignored req arrivals", cnt, 1);
        lit("ignored req floor", int'(floor), 5);

        reset = 1'b1; step(1'b0, 4'd0, 1'b1); reset = 1'b0;
        step(1'b1, 4'd4, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b0, 4'd0, 1'b1);
        lit("mid travel floor", int'(floor), 2);
        reset = 1'b1;
        #1;
        lit("async reset floor", int'(floor), 0);
        lit("async reset moving", int'(moving), 0);
        lit("async reset ready", int'(rif.req_ready), 1);
        model_reset();
        step(1'b0, 4'd0, 1'b1);
        reset = 1'b0;
        step(1'b1, 4'd1, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b0, 4'd0, 1'b1);
        lit("post reset arrival", int'(arrived) * 16 + int'(floor), 17);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
